// File: rtl/tluh_err_resp.sv
// TL-UH error responder: accepts one request at a time and answers it with d_error=1 beats.
// Optional first-error log enabled by defining TLUH_ERR_RESP_LOG_EN.
package tluh_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_IW  = 8;
  localparam int TL_SZW = 3;
  localparam int TL_DBW = TL_DW / 8;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGICAL     = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_IW-1:0]  a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_IW-1:0]  d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;
endpackage

module tluh_err_resp
  import tluh_pkg::*;
#(
  parameter int             DW       = TL_DW,
  parameter int             MAX_SIZE = 3,
  parameter logic [DW-1:0]  ERR_DATA = DW'(32'hFFFF_FFFF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  tluh_h2d_t        tl_h_i,
  output tluh_d2h_t        tl_h_o,
  input  logic             err_clr_i,
  output logic             err_valid_o,
  output logic [TL_AW-1:0] err_addr_o,
  output logic [TL_IW-1:0] err_src_o
);

  localparam int LB   = $clog2(DW / 8);
  localparam int CNTW = (MAX_SIZE > LB + 1) ? (MAX_SIZE - LB) : 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        rsp_op_q;
  logic              rsp_data_q;
  logic [TL_SZW-1:0] size_q;
  logic [TL_IW-1:0]  src_q;
  logic [CNTW-1:0]   cnt_q, last_cnt;
  logic              a_ready, d_valid, a_hs, d_hs, last_beat;
  logic [TL_SZW-1:0] size_clamped;
  logic [3:0]        map;

  // {multi-beat data response, D opcode}
  function automatic logic [3:0] map_op(input logic [2:0] op);
    case (op)
      OP_GET, OP_ARITH, OP_LOGICAL: map_op = {1'b1, D_ACCESS_ACK_DATA};
      OP_INTENT:                    map_op = {1'b0, D_HINT_ACK};
      default:                      map_op = {1'b0, D_ACCESS_ACK};
    endcase
  endfunction

  assign map          = map_op(tl_h_i.a_opcode);
  assign size_clamped = (tl_h_i.a_size > TL_SZW'(MAX_SIZE)) ? TL_SZW'(MAX_SIZE) : tl_h_i.a_size;
  assign a_hs         = tl_h_i.a_valid & a_ready;
  assign d_hs         = d_valid & tl_h_i.d_ready;

  // Only data responses wider than the bus span more than one beat.
  always_comb begin
    last_cnt = '0;
    if (rsp_data_q && (int'(size_q) > LB))
      last_cnt = CNTW'((1 << (int'(size_q) - LB)) - 1);
  end
  assign last_beat = (cnt_q == last_cnt);

  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    d_valid = 1'b0;
    case (state_q)
      IDLE: begin
        a_ready = 1'b1;
        if (tl_h_i.a_valid) state_d = RESP;
      end
      RESP: begin
        d_valid = 1'b1;
        if (tl_h_i.d_ready && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rsp_op_q   <= '0;
      rsp_data_q <= 1'b0;
      size_q     <= '0;
      src_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (a_hs) begin
        rsp_op_q   <= map[2:0];
        rsp_data_q <= map[3];
        size_q     <= size_clamped;
        src_q      <= tl_h_i.a_source;
      end
      if (d_hs) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.d_valid  = d_valid;
    tl_h_o.d_opcode = rsp_op_q;
    tl_h_o.d_size   = size_q;
    tl_h_o.d_source = src_q;
    tl_h_o.d_data   = TL_DW'(ERR_DATA);
    tl_h_o.d_error  = d_valid;
    tl_h_o.a_ready  = a_ready;
  end

`ifdef TLUH_ERR_RESP_LOG_EN
  logic             err_valid_q;
  logic [TL_AW-1:0] err_addr_q;
  logic [TL_IW-1:0] err_src_q;

  // A new acceptance in the same cycle as a clear re-arms the log with that request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_src_q   <= '0;
    end else if (a_hs && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= tl_h_i.a_address;
      err_src_q   <= tl_h_i.a_source;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_src_o   = err_src_q;

  logic unused_in;
  assign unused_in = ^{tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data};
`else
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_src_o   = '0;

  logic unused_in;
  assign unused_in = ^{tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data, tl_h_i.a_address, err_clr_i};
`endif

endmodule

// File: tb/tb_tluh_err_resp.sv
// Directed bench for tluh_err_resp: vector table of requests plus stall, reset and log sequences.
module tb_tluh_err_resp;
  import tluh_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  tluh_h2d_t        h;
  tluh_d2h_t        o;
  logic             err_clr;
  logic             err_valid;
  logic [TL_AW-1:0] err_addr;
  logic [TL_IW-1:0] err_src;

  int total = 0;
  int bad   = 0;

  tluh_err_resp dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h), .tl_h_o(o),
    .err_clr_i(err_clr), .err_valid_o(err_valid), .err_addr_o(err_addr), .err_src_o(err_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [7:0]  src;
    logic [31:0] addr;
    logic [2:0]  eop;
    logic [2:0]  esz;
    int          ebeats;
    bit          stall;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                      input logic [31:0] addr, input bit clr);
    @(posedge clk); #1;
    h.a_valid   = 1'b1;
    h.a_opcode  = op;
    h.a_param   = 3'($urandom_range(7));
    h.a_size    = sz;
    h.a_source  = src;
    h.a_address = addr;
    h.a_mask    = '1;
    h.a_data    = $urandom;
    err_clr     = clr;
    @(negedge clk);
    check("a_ready_idle", 64'(o.a_ready), 64'd1);
    @(posedge clk); #1;
    h.a_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Walks the response beat by beat; stall alternates d_ready 0/1 starting low.
  task automatic collect(input string tag, input logic [2:0] eop, input logic [2:0] esz,
                         input logic [7:0] esrc, input int ebeats, input bit stall);
    int beats = 0;
    int cyc   = 0;
    @(negedge clk);
    check({tag, ".first_valid"}, 64'(o.d_valid), 64'd1);
    while (o.d_valid && cyc < 40) begin
      check({tag, ".d_opcode"}, 64'(o.d_opcode), 64'(eop));
      check({tag, ".d_size"},   64'(o.d_size),   64'(esz));
      check({tag, ".d_source"}, 64'(o.d_source), 64'(esrc));
      check({tag, ".d_error"},  64'(o.d_error),  64'd1);
      check({tag, ".d_data"},   64'(o.d_data),   64'hFFFF_FFFF);
      check({tag, ".d_param"},  64'(o.d_param),  64'd0);
      check({tag, ".d_sink"},   64'(o.d_sink),   64'd0);
      check({tag, ".a_ready_busy"}, 64'(o.a_ready), 64'd0);
      h.d_ready = stall ? cyc[0] : 1'b1;
      if (h.d_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    check({tag, ".beats"},      64'(beats),     64'(ebeats));
    check({tag, ".d_valid_end"}, 64'(o.d_valid), 64'd0);
    check({tag, ".a_ready_end"}, 64'(o.a_ready), 64'd1);
    h.d_ready = 1'b1;
  endtask

  initial begin
    h       = '0;
    h.d_ready = 1'b1;
    err_clr = 1'b0;
    rst_n   = 1'b0;

    vt[0] = '{3'd4, 3'd2, 8'd5,   32'h4000_0000, 3'd1, 3'd2, 1, 1'b0};
    vt[1] = '{3'd2, 3'd3, 8'd3,   32'h0000_1000, 3'd1, 3'd3, 2, 1'b1};
    vt[2] = '{3'd0, 3'd2, 8'd1,   32'h0000_2000, 3'd0, 3'd2, 1, 1'b0};
    vt[3] = '{3'd5, 3'd2, 8'd2,   32'h0000_3000, 3'd2, 3'd2, 1, 1'b0};
    vt[4] = '{3'd7, 3'd6, 8'd9,   32'h0000_4000, 3'd0, 3'd3, 1, 1'b0};
    vt[5] = '{3'd3, 3'd3, 8'h7F,  32'h0000_5000, 3'd1, 3'd3, 2, 1'b0};
    vt[6] = '{3'd1, 3'd0, 8'd4,   32'h0000_6000, 3'd0, 3'd0, 1, 1'b1};
    vt[7] = '{3'd4, 3'd7, 8'd8,   32'h0000_7000, 3'd1, 3'd3, 2, 1'b1};
    vt[8] = '{3'd4, 3'd1, 8'hA5,  32'h0000_8000, 3'd1, 3'd1, 1, 1'b0};
    vt[9] = '{3'd6, 3'd3, 8'hFF,  32'h0000_9000, 3'd0, 3'd3, 1, 1'b0};

    #1;
    check("rst.d_valid",   64'(o.d_valid),   64'd0);
    check("rst.a_ready",   64'(o.a_ready),   64'd1);
    check("rst.d_error",   64'(o.d_error),   64'd0);
    check("rst.d_opcode",  64'(o.d_opcode),  64'd0);
    check("rst.d_size",    64'(o.d_size),    64'd0);
    check("rst.d_source",  64'(o.d_source),  64'd0);
    check("rst.err_valid", 64'(err_valid),   64'd0);
    check("rst.err_addr",  64'(err_addr),    64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifdef TLUH_ERR_RESP_LOG_EN
    send(3'd4, 3'd2, 8'h11, 32'h100, 1'b0);
    collect("log1", 3'd1, 3'd2, 8'h11, 1, 1'b0);
    send(3'd0, 3'd2, 8'h22, 32'h200, 1'b0);
    collect("log2", 3'd0, 3'd2, 8'h22, 1, 1'b0);
    check("log.keep_valid", 64'(err_valid), 64'd1);
    check("log.keep_addr",  64'(err_addr),  64'h100);
    check("log.keep_src",   64'(err_src),   64'h11);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("log.cleared", 64'(err_valid), 64'd0);
    send(3'd4, 3'd2, 8'h33, 32'h300, 1'b0);
    collect("log3", 3'd1, 3'd2, 8'h33, 1, 1'b0);
    check("log.new_valid", 64'(err_valid), 64'd1);
    check("log.new_addr",  64'(err_addr),  64'h300);
    check("log.new_src",   64'(err_src),   64'h33);
    send(3'd5, 3'd2, 8'h44, 32'h400, 1'b1);
    collect("log4", 3'd2, 3'd2, 8'h44, 1, 1'b0);
    check("log.clr_acc_valid", 64'(err_valid), 64'd1);
    check("log.clr_acc_addr",  64'(err_addr),  64'h400);
`else
    send(3'd4, 3'd2, 8'h11, 32'h100, 1'b1);
    collect("nolog", 3'd1, 3'd2, 8'h11, 1, 1'b0);
    check("nolog.valid", 64'(err_valid), 64'd0);
    check("nolog.addr",  64'(err_addr),  64'd0);
    check("nolog.src",   64'(err_src),   64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      send(vt[i].op, vt[i].sz, vt[i].src, vt[i].addr, 1'b0);
      collect($sformatf("vec%0d", i), vt[i].eop, vt[i].esz, vt[i].src, vt[i].ebeats, vt[i].stall);
    end

    // Reset asserted while a stalled response is pending.
    h.d_ready = 1'b0;
    send(3'd4, 3'd3, 8'd6, 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("rstmid.pre_valid", 64'(o.d_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.d_valid",  64'(o.d_valid),  64'd0);
    check("rstmid.a_ready",  64'(o.a_ready),  64'd1);
    check("rstmid.d_error",  64'(o.d_error),  64'd0);
    check("rstmid.d_opcode", 64'(o.d_opcode), 64'd0);
    check("rstmid.d_source", 64'(o.d_source), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    h.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid.idle_valid", 64'(o.d_valid), 64'd0);
      check("rstmid.idle_ready", 64'(o.a_ready), 64'd1);
    end
    send(3'd2, 3'd3, 8'h5A, 32'h0, 1'b0);
    collect("post_rst", 3'd1, 3'd3, 8'h5A, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
